// File: rtl/surf_img_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : surf_img_port_arbiter_if
// Brief    : Requester, response and BRAM-port bundle for the image port arbiter.
// Revision : 1.0
// ============================================================================
interface surf_img_port_arbiter_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 24
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic                  req0_last;
    logic                  req0_ready;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_data;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic                  req1_last;
    logic                  req1_ready;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_data;

    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_dout;

    logic                  busy;
    logic                  owner;

    // Requesters plus the image memory side.
    modport master (
        output req0_valid, req0_addr, req0_last,
        input  req0_ready, rsp0_valid, rsp0_data,
        output req1_valid, req1_addr, req1_last,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  mem_en, mem_addr,
        output mem_dout,
        input  busy, owner
    );

    modport slave (
        input  req0_valid, req0_addr, req0_last,
        output req0_ready, rsp0_valid, rsp0_data,
        input  req1_valid, req1_addr, req1_last,
        output req1_ready, rsp1_valid, rsp1_data,
        output mem_en, mem_addr,
        input  mem_dout,
        output busy, owner
    );
endinterface

`default_nettype wire

// File: rtl/surf_img_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : surf_img_port_arbiter
// Brief    : Round-robin burst arbiter sharing one image BRAM read port
//            between two requesters, with tagged in-order response routing.
// Revision : 1.0
// ============================================================================
module surf_img_port_arbiter #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 24,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    surf_img_port_arbiter_if.slave bus
);
    localparam int                 c_CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_BURST);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_OWN0 = 2'd1;
    localparam logic [1:0] c_OWN1 = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  r_owner;
    logic [c_CNT_W-1:0]    r_beat_cnt;
    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic                  w_ready0;
    logic                  w_ready1;
    logic                  w_acc0;
    logic                  w_acc1;
    logic                  w_acc;
    logic                  w_acc_last;
    logic                  w_release;
    logic                  w_rsp0;
    logic                  w_rsp1;
    logic [RD_LATENCY-1:0] r_tag_vld;
    logic [RD_LATENCY-1:0] r_tag_id;

    assign w_acc0     = bus.req0_valid & w_ready0;
    assign w_acc1     = bus.req1_valid & w_ready1;
    assign w_acc      = w_acc0 | w_acc1;
    assign w_acc_last = w_acc0 ? bus.req0_last : bus.req1_last;
    assign w_cnt_inc  = r_beat_cnt + c_ONE;
    // The IDLE beat sees a zero count, so MAX_BURST=1 releases on every beat.
    assign w_release  = w_acc & (w_acc_last | (w_cnt_inc == c_MAX_CNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_acc && !w_release) begin
                    w_state_next = w_acc0 ? c_OWN0 : c_OWN1;
                end
            end
            c_OWN0, c_OWN1: begin
                if (w_release) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // Tie in IDLE goes to the requester that did not hold the port last.
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        if (!rst) begin
            case (r_state)
                c_IDLE: begin
                    if (bus.req0_valid && (!bus.req1_valid || r_owner)) begin
                        w_ready0 = 1'b1;
                    end else if (bus.req1_valid) begin
                        w_ready1 = 1'b1;
                    end
                end
                c_OWN0:  w_ready0 = 1'b1;
                c_OWN1:  w_ready1 = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner    <= 1'b1;
            r_beat_cnt <= '0;
        end else begin
            if (w_acc) begin
                r_owner <= w_acc1;
            end
            if (w_state_next == c_IDLE) begin
                r_beat_cnt <= '0;
            end else if (w_acc) begin
                r_beat_cnt <= w_cnt_inc;
            end
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_tag_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tag_vld <= '0;
                    r_tag_id  <= '0;
                end else begin
                    r_tag_vld <= w_acc;
                    r_tag_id  <= w_acc1;
                end
            end
        end else begin : g_tag_shift
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tag_vld <= '0;
                    r_tag_id  <= '0;
                end else begin
                    r_tag_vld <= {r_tag_vld[RD_LATENCY-2:0], w_acc};
                    r_tag_id  <= {r_tag_id[RD_LATENCY-2:0], w_acc1};
                end
            end
        end
    endgenerate

    assign w_rsp0 = r_tag_vld[RD_LATENCY-1] & ~r_tag_id[RD_LATENCY-1];
    assign w_rsp1 = r_tag_vld[RD_LATENCY-1] &  r_tag_id[RD_LATENCY-1];

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.mem_en     = w_acc;
    assign bus.mem_addr   = w_acc0 ? bus.req0_addr :
                            w_acc1 ? bus.req1_addr : '0;
    assign bus.rsp0_valid = w_rsp0;
    assign bus.rsp1_valid = w_rsp1;
    assign bus.rsp0_data  = w_rsp0 ? bus.mem_dout : '0;
    assign bus.rsp1_data  = w_rsp1 ? bus.mem_dout : '0;
    assign bus.busy       = (r_state != c_IDLE) | (|r_tag_vld);
    assign bus.owner      = r_owner;
endmodule

`default_nettype wire

// File: tb/tb_surf_img_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_surf_img_port_arbiter
// Brief    : Scoreboard bench for the image port arbiter (latency 1 and 3).
// Revision : 1.0
// ============================================================================
module tb_surf_img_port_arbiter;
    localparam int c_AW = 17;
    localparam int c_DW = 24;

    typedef struct packed {
        logic            id;
        logic [c_DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   b_rsp1_seen = 0;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    surf_img_port_arbiter_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) bus_a ();
    surf_img_port_arbiter_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) bus_b ();

    surf_img_port_arbiter #(
        .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .RD_LATENCY(1), .MAX_BURST(16)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    surf_img_port_arbiter #(
        .ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW), .RD_LATENCY(3), .MAX_BURST(16)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    // Image content: one marked pixel, everything else derived from the address.
    function automatic logic [c_DW-1:0] pix(input logic [c_AW-1:0] a);
        return (a == 17'h00010) ? 24'hABCDEF : {7'h2A, a};
    endfunction

    logic [c_AW-1:0] mem_a_q;
    logic [c_AW-1:0] mem_b_q [3];
    always @(posedge clk) begin
        mem_a_q    <= bus_a.mem_addr;
        mem_b_q[0] <= bus_b.mem_addr;
        mem_b_q[1] <= mem_b_q[0];
        mem_b_q[2] <= mem_b_q[1];
    end
    assign bus_a.mem_dout = pix(mem_a_q);
    assign bus_b.mem_dout = pix(mem_b_q[2]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor for instance A: pops the scoreboard on every delivered pixel.
    always @(negedge clk) begin
        rsp_t e;
        if (!rst) begin
            check("rsp_exclusive", bus_a.rsp0_valid & bus_a.rsp1_valid, 0);
            if (bus_a.rsp0_valid || bus_a.rsp1_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", bus_a.rsp1_valid, e.id);
                    check("rsp_data", bus_a.rsp1_valid ? bus_a.rsp1_data : bus_a.rsp0_data, e.data);
                end
            end
            if (!bus_a.rsp0_valid) check("rsp0_data_idle", bus_a.rsp0_data, 0);
            if (!bus_a.rsp1_valid) check("rsp1_data_idle", bus_a.rsp1_data, 0);
        end
    end

    always @(negedge clk) begin
        if (bus_b.rsp1_valid) b_rsp1_seen++;
    end

    // One cycle of stimulus on instance A with hand-computed readies.
    task automatic beat(input logic v0, input logic [c_AW-1:0] a0, input logic l0,
                        input logic v1, input logic [c_AW-1:0] a1, input logic l1,
                        input logic e0, input logic e1);
        @(negedge clk);
        bus_a.req0_valid = v0;
        bus_a.req0_addr  = a0;
        bus_a.req0_last  = l0;
        bus_a.req1_valid = v1;
        bus_a.req1_addr  = a1;
        bus_a.req1_last  = l1;
        #1;
        check("req0_ready", bus_a.req0_ready, e0);
        check("req1_ready", bus_a.req1_ready, e1);
        check("mem_en", bus_a.mem_en, (v0 & e0) | (v1 & e1));
        if (v0 && e0) begin
            check("mem_addr0", bus_a.mem_addr, a0);
            exp_q.push_back('{id: 1'b0, data: pix(a0)});
        end else if (v1 && e1) begin
            check("mem_addr1", bus_a.mem_addr, a1);
            exp_q.push_back('{id: 1'b1, data: pix(a1)});
        end else begin
            check("mem_addr_idle", bus_a.mem_addr, 0);
        end
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) beat(0, '0, 0, 0, '0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rst_b = 1'b1;
        bus_a.req0_valid = 0; bus_a.req0_addr = '0; bus_a.req0_last = 0;
        bus_a.req1_valid = 0; bus_a.req1_addr = '0; bus_a.req1_last = 0;
        bus_b.req0_valid = 0; bus_b.req0_addr = '0; bus_b.req0_last = 0;
        bus_b.req1_valid = 0; bus_b.req1_addr = '0; bus_b.req1_last = 0;
        repeat (3) @(negedge clk);

        // Outputs held quiet under reset even with both requesters valid.
        bus_a.req0_valid = 1; bus_a.req1_valid = 1;
        #1;
        check("rst_ready0", bus_a.req0_ready, 0);
        check("rst_ready1", bus_a.req1_ready, 0);
        check("rst_mem_en", bus_a.mem_en, 0);
        check("rst_mem_addr", bus_a.mem_addr, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_owner", bus_a.owner, 1);
        check("rst_rsp0", bus_a.rsp0_valid, 0);
        bus_a.req0_valid = 0; bus_a.req1_valid = 0;
        @(negedge clk);
        rst = 1'b0;

        // Alternating single-beat ties: grants 0,1,0,1 with owner toggling.
        beat(1, 17'h20, 1, 1, 17'h30, 1, 1, 0); check("owner_c1", bus_a.owner, 1);
        beat(1, 17'h21, 1, 1, 17'h30, 1, 0, 1); check("owner_c2", bus_a.owner, 0);
        beat(1, 17'h21, 1, 1, 17'h31, 1, 1, 0); check("owner_c3", bus_a.owner, 1);
        beat(1, 17'h22, 1, 1, 17'h31, 1, 0, 1); check("owner_c4", bus_a.owner, 0);
        idle_a(2);

        // Four-beat burst from requester 0 holds off requester 1 until cycle 5.
        for (int i = 0; i < 4; i++) beat(1, 17'h100 + i, i == 3, 1, 17'h200, 1, 1, 0);
        beat(0, '0, 0, 1, 17'h200, 1, 0, 1);
        idle_a(2);

        // Single read of the marked pixel; busy while the tag is in flight.
        beat(1, 17'h10, 1, 0, '0, 0, 1, 0);
        idle_a(1);
        check("busy_inflight", bus_a.busy, 1);
        idle_a(1);
        check("busy_drained", bus_a.busy, 0);
        check("owner_after_single", bus_a.owner, 0);

        // Twenty beats without last: forced release after beat 16.
        for (int i = 0; i < 16; i++) beat(1, 17'h400 + i, 0, i > 0, 17'h300, 1, 1, 0);
        beat(1, 17'h410, 0, 1, 17'h300, 1, 0, 1);
        for (int i = 16; i < 20; i++) beat(1, 17'h400 + i, i == 19, 0, '0, 0, 1, 0);
        idle_a(2);

        // Owner stalls for five cycles mid-burst; requester 1 stays blocked.
        beat(1, 17'h500, 0, 0, '0, 0, 1, 0);
        beat(1, 17'h501, 0, 0, '0, 0, 1, 0);
        for (int i = 0; i < 5; i++) beat(0, '0, 0, 1, 17'h600, 1, 1, 0);
        beat(1, 17'h502, 1, 1, 17'h600, 1, 1, 0);
        beat(0, '0, 0, 1, 17'h600, 1, 0, 1);
        idle_a(3);
        check("scoreboard_empty", exp_q.size(), 0);

        // Instance B (latency 3): reset must discard in-flight reads.
        bus_b.req0_valid = 1; bus_b.req1_valid = 1;
        #1;
        check("b_rst_ready0", bus_b.req0_ready, 0);
        check("b_rst_ready1", bus_b.req1_ready, 0);
        check("b_rst_mem_en", bus_b.mem_en, 0);
        bus_b.req0_valid = 0; bus_b.req1_valid = 0;
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        bus_b.req1_valid = 1; bus_b.req1_addr = 17'h700; bus_b.req1_last = 0;
        #1 check("b_r1_beat1", bus_b.req1_ready, 1);
        @(negedge clk);
        bus_b.req1_addr = 17'h701; bus_b.req1_last = 1;
        #1 check("b_r1_beat2", bus_b.req1_ready, 1);
        @(negedge clk);
        bus_b.req1_valid = 0;
        #1 check("b_busy_inflight", bus_b.busy, 1);
        rst_b = 1'b1;
        #1;
        check("b_busy_rst", bus_b.busy, 0);
        check("b_rsp1_rst", bus_b.rsp1_valid, 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        bus_b.req0_valid = 1; bus_b.req0_addr = 17'h710; bus_b.req0_last = 1;
        bus_b.req1_valid = 1; bus_b.req1_addr = 17'h720; bus_b.req1_last = 1;
        #1;
        check("b_tie_ready0", bus_b.req0_ready, 1);
        check("b_tie_ready1", bus_b.req1_ready, 0);
        @(negedge clk);
        bus_b.req0_valid = 0; bus_b.req1_valid = 0;
        #1 check("b_rsp0_lat1", bus_b.rsp0_valid, 0);
        @(negedge clk);
        #1 check("b_rsp0_lat2", bus_b.rsp0_valid, 0);
        @(negedge clk);
        #1;
        check("b_rsp0_lat3", bus_b.rsp0_valid, 1);
        check("b_rsp0_data", bus_b.rsp0_data, 24'h2A0710 & 24'hFFFFFF ? {7'h2A, 17'h710} : 24'h0);
        repeat (6) @(negedge clk);
        check("b_no_rsp1", b_rsp1_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
